// File: rtl/instr_enc_loader_pkg.sv
// Shared MIPS encoding definitions: instruction kinds, opcodes, field positions
// and small word-building helpers used by the loader and the main decoder.
package mips_enc_pkg;

  typedef enum logic [3:0] {
    RTYPE = 4'd0,
    LW    = 4'd1,
    SW    = 4'd2,
    BEQ   = 4'd3,
    J     = 4'd4,
    ADDI  = 4'd5,
    LUI   = 4'd6,
    BNE   = 4'd7,
    JAL   = 4'd8,
    SLTI  = 4'd9
  } instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL,
    ST_DRAIN
  } load_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  // Opcode lookup for every kind; legality is decided by the encoder.
  function automatic logic [5:0] opcode_of(instr_kind_e kind);
    case (kind)
      RTYPE:   return OP_RTYPE;
      LW:      return OP_LW;
      SW:      return OP_SW;
      BEQ:     return OP_BEQ;
      J:       return OP_J;
      ADDI:    return OP_ADDI;
      LUI:     return OP_LUI;
      BNE:     return OP_BNE;
      JAL:     return OP_JAL;
      SLTI:    return OP_SLTI;
      default: return OP_RTYPE;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] shamt, logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6]    = OP_RTYPE;
    w[RS_LSB +: 5]    = rs;
    w[RT_LSB +: 5]    = rt;
    w[RD_LSB +: 5]    = rd;
    w[SHAMT_LSB +: 5] = shamt;
    w[5:0]            = funct;
    return w;
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[15:0]        = imm;
    return w;
  endfunction

  function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[25:0]        = target;
    return w;
  endfunction

endpackage

// File: rtl/instr_enc_loader_if.sv
// Request and instruction-memory write bundle for instr_enc_loader.
// master: boot host / memory side; slave: the loader itself.
interface instr_enc_loader_if import mips_enc_pkg::*; #(
  parameter int AW = 32
) ();

  logic              start;
  logic              finish;
  logic              req_valid;
  logic              req_ready;
  instr_kind_e       req_kind;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [4:0]        req_shamt;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic              imem_ready;
  logic [AW-1:0]     imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [6:0]        count;
  logic              err;

  modport master (
    output start, finish, req_valid, req_kind, req_rs, req_rt, req_rd,
           req_shamt, req_funct, req_imm, req_target, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err
  );

  modport slave (
    input  start, finish, req_valid, req_kind, req_rs, req_rt, req_rd,
           req_shamt, req_funct, req_imm, req_target, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err
  );

endinterface

// File: rtl/instr_enc_loader_word_enc.sv
// instr_word_enc: combinational kind + fields -> 32-bit MIPS word and legality.
// Optional macro INSTR_EXT_OPS_EN enables LUI, BNE, JAL and SLTI; without it
// those kinds report illegal.
module instr_word_enc import mips_enc_pkg::*; (
  input  instr_kind_e kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic [5:0] op;

  // Build the word from only the fields the kind uses; unknown kinds stay illegal.
  always_comb begin
    op      = opcode_of(kind_i);
    word_o  = '0;
    legal_o = 1'b0;
    case (kind_i)
      RTYPE: begin
        word_o  = enc_r(rs_i, rt_i, rd_i, shamt_i, funct_i);
        legal_o = 1'b1;
      end
      LW, SW, BEQ, ADDI: begin
        word_o  = enc_i(op, rs_i, rt_i, imm_i);
        legal_o = 1'b1;
      end
      J: begin
        word_o  = enc_j(op, target_i);
        legal_o = 1'b1;
      end
`ifdef INSTR_EXT_OPS_EN
      BNE, SLTI: begin
        word_o  = enc_i(op, rs_i, rt_i, imm_i);
        legal_o = 1'b1;
      end
      LUI: begin
        word_o  = enc_i(op, 5'd0, rt_i, imm_i);
        legal_o = 1'b1;
      end
      JAL: begin
        word_o  = enc_j(op, target_i);
        legal_o = 1'b1;
      end
`endif
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_enc_loader.sv
// instr_enc_loader: encodes instruction requests and streams them into imem at
// sequential word addresses through a single registered output stage.
// Optional macro INSTR_EXT_OPS_EN enables the extended kinds in the encoder.
module instr_enc_loader import mips_enc_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          AW        = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_enc_loader_if.slave  bus
);

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  load_state_e   state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [6:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          done_c;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic [7:0]    occupancy;
  logic          write_fire;
  logic          req_ready_c;
  logic          accept;

  instr_word_enc u_enc (
    .kind_i   (bus.req_kind),
    .rs_i     (bus.req_rs),
    .rt_i     (bus.req_rt),
    .rd_i     (bus.req_rd),
    .shamt_i  (bus.req_shamt),
    .funct_i  (bus.req_funct),
    .imm_i    (bus.req_imm),
    .target_i (bus.req_target),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  // Words written plus the one waiting in the output register must stay below DEPTH.
  assign occupancy   = {1'b0, count_q} + {7'd0, we_q};
  assign write_fire  = we_q && bus.imem_ready;
  assign req_ready_c = (state_q == ST_LOAD) && (!we_q || bus.imem_ready) && (occupancy < DEPTH_W);
  assign accept      = bus.req_valid && req_ready_c;

  // Next-state logic for the session FSM, output stage, address and counters.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    done_c  = 1'b0;

    if (write_fire) begin
      we_d    = 1'b0;
      addr_d  = addr_q + AW'(4);
      count_d = count_q + 7'd1;
    end

    if (accept) begin
      if (enc_legal) begin
        we_d    = 1'b1;
        wdata_d = enc_word;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          addr_d  = AW'(BASE_ADDR);
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.finish) begin
          state_d = ST_DRAIN;
        end else if ({1'b0, count_q} == DEPTH_W) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.req_valid) begin
          err_d = 1'b1;
        end
        if (bus.finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!we_q) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any pending write and returns to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= AW'(BASE_ADDR);
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_c;
  assign bus.count      = count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Scoreboard bench for instr_enc_loader: directed cases followed by random
// sessions, checked against an arithmetic MIPS encoding model.
module tb_instr_enc_loader;
  import mips_enc_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int          MAX_WAIT = 40;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  instr_enc_loader_if #(.AW(32)) bus ();

  instr_enc_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .AW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        expQ[$];
  exp_t        popped;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] nextAddr = BASE;
  int          expCount = 0;
  logic        expErr = 1'b0;
  bit          readyRandom = 1'b0;
  logic        readyForce = 1'b1;
  bit          holding = 1'b0;
  logic [31:0] holdAddr = '0;
  logic [31:0] holdWord = '0;

  always #5 clk = ~clk;

  // Memory side: ready changes just after each rising edge.
  always @(posedge clk) begin
    #2;
    bus.imem_ready = readyRandom ? ($urandom_range(0, 3) != 0) : readyForce;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input int cycles);
    checks++;
    fails++;
    $display("[TB] FAIL %s: no response after %0d cycles, required within %0d", name, cycles, cycles);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic longint opTable(input int kind);
    case (kind)
      0: return 0;
      1: return 35;
      2: return 43;
      3: return 4;
      4: return 2;
      5: return 8;
      6: return 15;
      7: return 5;
      8: return 3;
      9: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit modelLegal(input int kind);
`ifdef INSTR_EXT_OPS_EN
    return (kind >= 0) && (kind <= 9);
`else
    return (kind >= 0) && (kind <= 5);
`endif
  endfunction

  // Plain weighted-sum encoding: opcode*2^26 + rs*2^21 + rt*2^16 + ...
  function automatic logic [31:0] modelWord(input int kind, input int rs, input int rt, input int rd,
                                            input int shamt, input int funct, input int imm,
                                            input int target);
    longint op;
    longint w;
    op = opTable(kind);
    case (kind)
      0:       w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + shamt * 64 + funct;
      4, 8:    w = op * 67108864 + target;
      6:       w = op * 67108864 + rt * 65536 + imm;
      default: w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
    endcase
    return 32'(w);
  endfunction

  // Present one request and hold it until accepted; queue what memory should see.
  task automatic applyStimulus(input int kind, input int rs, input int rt, input int rd,
                               input int shamt, input int funct, input int imm, input int target,
                               input bit useFixed, input logic [31:0] fixedWord, output int waited);
    bit taken;
    exp_t e;
    taken  = 1'b0;
    waited = MAX_WAIT;
    bus.req_kind   = instr_kind_e'(4'(kind));
    bus.req_rs     = 5'(rs);
    bus.req_rt     = 5'(rt);
    bus.req_rd     = 5'(rd);
    bus.req_shamt  = 5'(shamt);
    bus.req_funct  = 6'(funct);
    bus.req_imm    = 16'(imm);
    bus.req_target = 26'(target);
    bus.req_valid  = 1'b1;
    for (int i = 0; i < MAX_WAIT && !taken; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        taken  = 1'b1;
        waited = i;
        if (modelLegal(kind)) begin
          e.addr = nextAddr;
          e.word = useFixed ? fixedWord : modelWord(kind, rs, rt, rd, shamt, funct, imm, target);
          expQ.push_back(e);
          nextAddr = nextAddr + 32'd4;
          expCount++;
        end else begin
          expErr = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!taken) failNow("accept", MAX_WAIT);
  endtask

  task automatic startSession(input bit withFinish);
    bus.start  = 1'b1;
    bus.finish = withFinish;
    tick(1);
    bus.start  = 1'b0;
    bus.finish = 1'b0;
    nextAddr   = BASE;
    expCount   = 0;
  endtask

  task automatic finishSession();
    bit seen;
    seen = 1'b0;
    bus.finish = 1'b1;
    tick(1);
    bus.finish = 1'b0;
    for (int i = 0; i < MAX_WAIT && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        checkOutput("count_at_done", 32'(bus.count), 32'(expCount));
        checkOutput("err_at_done", 32'(bus.err), 32'(expErr));
        checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      failNow("done", MAX_WAIT);
    end else begin
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
      checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetDut(input bit checkState);
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.start     = 1'b0;
    bus.finish    = 1'b0;
    expQ.delete();
    expErr   = 1'b0;
    expCount = 0;
    nextAddr = BASE;
    tick(2);
    if (checkState) begin
      @(negedge clk);
      checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
      checkOutput("rst_imem_addr", bus.imem_addr, BASE);
      checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
      checkOutput("rst_count", 32'(bus.count), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every write handshake and checks stalls hold.
  always @(negedge clk) begin
    if (!reset_n) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        checkOutput("hold_we", 32'(bus.imem_we), 32'd1);
        checkOutput("hold_addr", bus.imem_addr, holdAddr);
        checkOutput("hold_data", bus.imem_wdata, holdWord);
      end
      holding = 1'b0;
      if (bus.imem_we) begin
        if (bus.imem_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_write: got 0x%08h @0x%08h, expected no write",
                     bus.imem_wdata, bus.imem_addr);
          end else begin
            popped = expQ.pop_front();
            checkOutput("write_addr", bus.imem_addr, popped.addr);
            checkOutput("write_data", bus.imem_wdata, popped.word);
          end
        end else begin
          holding  = 1'b1;
          holdAddr = bus.imem_addr;
          holdWord = bus.imem_wdata;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    bus.start      = 1'b0;
    bus.finish     = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_kind   = RTYPE;
    bus.req_rs     = '0;
    bus.req_rt     = '0;
    bus.req_rd     = '0;
    bus.req_shamt  = '0;
    bus.req_funct  = '0;
    bus.req_imm    = '0;
    bus.req_target = '0;
    resetDut(1'b1);

    // start and finish together in IDLE: start wins; ADDI with junk in unused fields
    startSession(1'b1);
    @(negedge clk);
    checkOutput("start_wins_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(5, 0, 8, 31, 31, 63, 5, 26'h3FF_FFFF, 1'b1, 32'h2008_0005, w);
    finishSession();

    // back-to-back LW/SW, start while busy ignored, then BEQ and J
    startSession(1'b0);
    applyStimulus(1, 29, 8, 0, 0, 0, 4, 0, 1'b1, 32'h8FA8_0004, w);
    applyStimulus(2, 29, 8, 0, 0, 0, 8, 0, 1'b1, 32'hAFA8_0008, w);
    checkOutput("back_to_back_wait", 32'(w), 32'd0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    applyStimulus(3, 8, 9, 0, 0, 0, 2, 0, 1'b1, 32'h1109_0002, w);
    applyStimulus(4, 7, 7, 7, 7, 7, 16'hFFFF, 26'h10, 1'b1, 32'h0800_0010, w);
    finishSession();

    // RTYPE held under a three-cycle memory stall
    startSession(1'b0);
    readyForce = 1'b0;
    applyStimulus(0, 8, 9, 10, 0, 32, 16'hBEEF, 26'h3FF_FFFF, 1'b1, 32'h0109_5020, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ready_while_stalled", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    readyForce = 1'b1;
    finishSession();

    // fill to DEPTH, keep requesting while FULL
    startSession(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(5, i, i + 1, 0, 0, 0, 100 + i, 0, 1'b0, 32'h0, w);
    end
    bus.req_kind  = ADDI;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("ready_when_full", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    expErr = 1'b1;
    @(negedge clk);
    checkOutput("err_req_while_full", 32'(bus.err), 32'd1);
    checkOutput("busy_while_full", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    finishSession();
    resetDut(1'b0);

    // LUI: encoded with extended ops, otherwise consumed as illegal
    startSession(1'b0);
    applyStimulus(6, 5, 8, 0, 0, 0, 16'h1234, 0, 1'b1, 32'h3C08_1234, w);
    finishSession();
    resetDut(1'b0);

    // reset in the middle of a stalled write
    startSession(1'b0);
    readyForce = 1'b0;
    applyStimulus(5, 1, 2, 0, 0, 0, 77, 0, 1'b0, 32'h0, w);
    tick(2);
    reset_n = 1'b0;
    expQ.delete();
    tick(1);
    @(negedge clk);
    checkOutput("we_after_reset", 32'(bus.imem_we), 32'd0);
    checkOutput("count_after_reset", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    readyForce = 1'b1;
    expErr     = 1'b0;
    expCount   = 0;
    @(negedge clk);
    checkOutput("no_write_after_reset", 32'(bus.imem_we), 32'd0);
    @(posedge clk);
    #1;

    // random sessions with random memory backpressure
    readyRandom = 1'b1;
    for (int s = 0; s < 25; s++) begin
      int n;
      n = int'($urandom_range(0, DEPTH));
      startSession(1'b0);
      for (int r = 0; r < n; r++) begin
        int k;
        int sel;
        sel = int'($urandom_range(0, 9));
        k   = (sel < 8) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
        applyStimulus(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 67108863)), 1'b0, 32'h0, w);
        tick(int'($urandom_range(0, 1)));
      end
      finishSession();
      if (expErr) resetDut(1'b0);
    end
    readyRandom = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
